// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared serial-audio definitions: output format encodings and
//               a constant clog2 helper used for port and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam logic [1:0] MODE_I2S = 2'd0;
    localparam logic [1:0] MODE_LJ  = 2'd1;
    localparam logic [1:0] MODE_TDM = 2'd2;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_frame_fifo
// Description : Show-ahead FIFO of whole audio frames. q always presents the
//               oldest stored frame; writes while full and reads while empty
//               are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    aclr_n,
    input  logic [WIDTH-1:0]        data,
    input  logic                    wrreq,
    input  logic                    rdreq,
    output logic [WIDTH-1:0]        q,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   usedw
);

    localparam int c_aw = clog2(DEPTH);
    localparam int c_uw = c_aw + 1;
    localparam logic [c_uw-1:0] c_depth = c_uw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_uw-1:0]  r_used;
    logic             w_wr;
    logic             w_rd;

    assign w_wr  = wrreq && !full;
    assign w_rd  = rdreq && !empty;
    assign full  = (r_used == c_depth);
    assign empty = (r_used == '0);
    assign usedw = r_used;
    assign q     = r_mem[r_rptr];

    // Frame storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= data;
        end
    end

    // Pointers and occupancy; a simultaneous write and read keep the count.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_used <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_used <= r_used + 1'b1;
                2'b01:   r_used <= r_used - 1'b1;
                default: r_used <= r_used;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tdm_out.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tdm_out
// Description : Multi-channel serial audio transmitter. Buffers frames in a
//               FIFO, divides clk down to sck/bck and shifts frames out MSB
//               first in I2S, left-justified or TDM format.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_out
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = 32,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int BCK_DIV    = 4,
    parameter int SCK_DIV    = 2
) (
    input  logic                            clk,
    input  logic                            aclr_n,
    input  logic [CHANNELS*SAMPLE_W-1:0]    sample,
    input  logic                            wrreq,
    output logic                            wrfull,
    output logic [clog2(FIFO_DEPTH):0]      wrusedw,
    input  logic [1:0]                      mode,
    input  logic                            clr_status,
    output logic                            underrun,
    output logic                            overflow,
    output logic                            sck,
    output logic                            bck,
    output logic                            lrck,
    output logic                            dout
);

    localparam int c_frame = CHANNELS * SAMPLE_W;
    localparam int c_bw    = clog2(c_frame);
    localparam int c_dw    = clog2(BCK_DIV);
    localparam int c_sw    = clog2(SCK_DIV);

    localparam logic [c_dw-1:0] c_bck_rise  = c_dw'(BCK_DIV / 2 - 1);
    localparam logic [c_dw-1:0] c_bck_fall  = c_dw'(BCK_DIV - 1);
    localparam logic [c_sw-1:0] c_sck_rise  = c_sw'(SCK_DIV / 2 - 1);
    localparam logic [c_sw-1:0] c_sck_fall  = c_sw'(SCK_DIV - 1);
    localparam logic [c_bw-1:0] c_last_slot = c_bw'(c_frame - 1);
    // More than two channels can only be carried as TDM, so start in that format.
    localparam logic [1:0] c_reset_mode = (CHANNELS > 2) ? MODE_TDM : MODE_I2S;

    logic [c_dw-1:0]    r_dcnt;
    logic [c_sw-1:0]    r_scnt;
    logic               r_bck;
    logic               r_sck;
    logic [c_bw-1:0]    r_bcnt;
    logic [c_frame-1:0] r_sr;
    logic [1:0]         r_mode;
    logic               r_lrck;
    logic               r_dout;
    logic               r_underrun;
    logic               r_overflow;

    logic               w_fall;
    logic               w_start;
    logic               w_pop;
    logic               w_empty;
    logic [c_frame-1:0] w_fifo_q;
    logic [c_bw-1:0]    w_bcnt_next;
    logic [c_frame-1:0] w_sr_next;
    logic [1:0]         w_mode_in;
    logic [1:0]         w_mode_next;
    logic               w_ws;
    logic               w_lrck_next;

    audio_frame_fifo #(
        .WIDTH (c_frame),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .aclr_n (aclr_n),
        .data   (sample),
        .wrreq  (wrreq),
        .rdreq  (w_pop),
        .q      (w_fifo_q),
        .full   (wrfull),
        .empty  (w_empty),
        .usedw  (wrusedw)
    );

    // Bit clock divider; the cycle bck drops is the fall event driving the serialiser.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_dcnt <= '0;
            r_bck  <= 1'b0;
        end else begin
            r_dcnt <= w_fall ? '0 : r_dcnt + 1'b1;
            if (r_dcnt == c_bck_rise) begin
                r_bck <= 1'b1;
            end else if (w_fall) begin
                r_bck <= 1'b0;
            end
        end
    end

    // Master clock divider, independent of the bit clock.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_scnt <= '0;
            r_sck  <= 1'b0;
        end else begin
            r_scnt <= (r_scnt == c_sck_fall) ? '0 : r_scnt + 1'b1;
            if (r_scnt == c_sck_rise) begin
                r_sck <= 1'b1;
            end else if (r_scnt == c_sck_fall) begin
                r_sck <= 1'b0;
            end
        end
    end

    // Word select for stereo formats: high while the slot belongs to channel 1.
    generate
        if (CHANNELS == 2) begin : g_stereo
            assign w_ws = (w_bcnt_next >= c_bw'(SAMPLE_W));
        end else begin : g_mono
            assign w_ws = 1'b0;
        end
    endgenerate

    // Slot sequencing, frame load and format selection for the coming slot.
    always_comb begin
        w_fall      = (r_dcnt == c_bck_fall);
        w_start     = w_fall && (r_bcnt == c_last_slot);
        w_pop       = w_start && !w_empty;
        w_bcnt_next = w_start ? '0 : r_bcnt + 1'b1;

        w_mode_in = MODE_LJ;
        if (CHANNELS > 2) begin
            w_mode_in = MODE_TDM;
        end else if (mode == MODE_I2S) begin
            w_mode_in = MODE_I2S;
        end else if (mode == MODE_TDM) begin
            w_mode_in = MODE_TDM;
        end
        w_mode_next = w_start ? w_mode_in : r_mode;

        if (w_start) begin
            w_sr_next = w_pop ? w_fifo_q : '0;
        end else begin
            w_sr_next = {r_sr[c_frame-2:0], 1'b0};
        end

        // TDM frame sync sits in the last slot, one bck ahead of the ch0 MSB.
        w_lrck_next = (w_mode_next == MODE_TDM) ? (w_bcnt_next == c_last_slot) : w_ws;
    end

    // Serialiser state; all pin-visible data changes happen on fall events only.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_bcnt <= '0;
            r_sr   <= '0;
            r_mode <= c_reset_mode;
            r_lrck <= 1'b0;
            r_dout <= 1'b0;
        end else if (w_fall) begin
            r_bcnt <= w_bcnt_next;
            r_sr   <= w_sr_next;
            r_mode <= w_mode_next;
            r_lrck <= w_lrck_next;
            // I2S delays data one slot, so it emits the bit that was current before this event.
            r_dout <= (w_mode_next == MODE_I2S) ? r_sr[c_frame-1] : w_sr_next[c_frame-1];
        end
    end

    // Sticky status; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_underrun <= (w_start && w_empty) || (r_underrun && !clr_status);
            r_overflow <= (wrreq && wrfull) || (r_overflow && !clr_status);
        end
    end

    assign sck      = r_sck;
    assign bck      = r_bck;
    assign lrck     = r_lrck;
    assign dout     = r_dout;
    assign underrun = r_underrun;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tdm_out
// Description : Self-checking bench for i2s_tdm_out. A stereo instance with
//               default parameters and a 4x16 TDM instance share clock and
//               reset; a DAC-style monitor per instance captures lrck/dout on
//               every bck rising edge for frame decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_out;

    logic        clk;
    logic        aclr_n;

    logic [63:0] sample0;
    logic        wrreq0;
    logic        wrfull0;
    logic [2:0]  wrusedw0;
    logic [1:0]  mode0;
    logic        clr0;
    logic        underrun0, overflow0, sck0, bck0, lrck0, dout0;

    logic [63:0] sample4;
    logic        wrreq4;
    logic        wrfull4;
    logic [2:0]  wrusedw4;
    logic [1:0]  mode4;
    logic        clr4;
    logic        underrun4, overflow4, sck4, bck4, lrck4, dout4;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;

    i2s_tdm_out dut (
        .clk(clk), .aclr_n(aclr_n), .sample(sample0), .wrreq(wrreq0),
        .wrfull(wrfull0), .wrusedw(wrusedw0), .mode(mode0), .clr_status(clr0),
        .underrun(underrun0), .overflow(overflow0), .sck(sck0), .bck(bck0),
        .lrck(lrck0), .dout(dout0)
    );

    i2s_tdm_out #(.SAMPLE_W(16), .CHANNELS(4)) dut4 (
        .clk(clk), .aclr_n(aclr_n), .sample(sample4), .wrreq(wrreq4),
        .wrfull(wrfull4), .wrusedw(wrusedw4), .mode(mode4), .clr_status(clr4),
        .underrun(underrun4), .overflow(overflow4), .sck(sck4), .bck(bck4),
        .lrck(lrck4), .dout(dout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge count since reset release: edge N leaves ecnt == N.
    always @(posedge clk) begin
        ecnt <= aclr_n ? ecnt + 1 : 0;
    end

    // DAC model: capture lrck/dout at each bck rise, one entry per slot.
    logic lr0 [1024];
    logic d0  [1024];
    logic lr4 [1024];
    logic d4  [1024];
    int   g0 = 0;
    int   g4 = 0;
    logic pb0 = 1'b0;
    logic pb4 = 1'b0;

    always @(negedge clk) begin
        if (!aclr_n) begin
            g0  <= 0;
            g4  <= 0;
            pb0 <= 1'b0;
            pb4 <= 1'b0;
        end else begin
            if (bck0 && !pb0 && g0 < 1024) begin
                lr0[g0] <= lrck0;
                d0[g0]  <= dout0;
                g0      <= g0 + 1;
            end
            if (bck4 && !pb4 && g4 < 1024) begin
                lr4[g4] <= lrck4;
                d4[g4]  <= dout4;
                g4      <= g4 + 1;
            end
            pb0 <= bck0;
            pb4 <= bck4;
        end
    end

    typedef struct {
        int   edge_no;
        logic bck;
        logic sck;
    } div_vec_t;

    typedef struct {
        logic [63:0] smp;
        logic [2:0]  used;
        logic        full;
        logic        ovf;
    } fifo_vec_t;

    div_vec_t  dvec [5];
    fifo_vec_t fvec [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        int budget;
        budget = 0;
        while (ecnt < n) begin
            @(negedge clk);
            budget++;
            if (budget > n + 1000) begin
                checks++;
                failures++;
                $display("FAIL edge_timeout: got %0d edges required %0d", ecnt, n);
                return;
            end
        end
    endtask

    task automatic wait_slot(input bit quad, input int n);
        int budget;
        budget = 0;
        while ((quad ? g4 : g0) < n) begin
            @(negedge clk);
            budget++;
            if (budget > n * 8 + 2000) begin
                checks++;
                failures++;
                $display("FAIL slot_timeout: got %0d slots required %0d", quad ? g4 : g0, n);
                return;
            end
        end
    endtask

    // sel: 0 = dut dout, 1 = dut lrck, 2 = dut4 dout, 3 = dut4 lrck
    function automatic logic bitat(input int sel, input int idx);
        case (sel)
            0:       return d0[idx];
            1:       return lr0[idx];
            2:       return d4[idx];
            default: return lr4[idx];
        endcase
    endfunction

    function automatic int ones(input int sel, input int first, input int last);
        int n;
        n = 0;
        for (int i = first; i <= last; i++) begin
            if (bitat(sel, i) === 1'b1) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] word(input int sel, input int start, input int width);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < width; i++) begin
            w = {w[30:0], bitat(sel, start + i)};
        end
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        aclr_n  = 1'b0;
        wrreq0  = 1'b0;
        wrreq4  = 1'b0;
        clr0    = 1'b0;
        clr4    = 1'b0;
        sample0 = '0;
        sample4 = '0;
        mode0   = 2'd0;
        mode4   = 2'd1;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {wrfull0, wrusedw0, underrun0, overflow0, sck0, bck0, lrck0, dout0}, '0);
        aclr_n = 1'b1;
    endtask

    initial begin
        dvec[0] = '{1, 1'b0, 1'b1};
        dvec[1] = '{2, 1'b1, 1'b0};
        dvec[2] = '{3, 1'b1, 1'b1};
        dvec[3] = '{4, 1'b0, 1'b0};
        dvec[4] = '{5, 1'b0, 1'b1};

        fvec[0] = '{{32'hA000_0001, 32'hB000_0001}, 3'd1, 1'b0, 1'b0};
        fvec[1] = '{{32'hA000_0002, 32'hB000_0002}, 3'd2, 1'b0, 1'b0};
        fvec[2] = '{{32'hA000_0003, 32'hB000_0003}, 3'd3, 1'b0, 1'b0};
        fvec[3] = '{{32'hA000_0004, 32'hB000_0004}, 3'd4, 1'b1, 1'b0};
        fvec[4] = '{{32'hA000_0005, 32'hB000_0005}, 3'd4, 1'b1, 1'b1};

        aclr_n = 1'b0;

        // ---- Left-justified stereo and 4x16 TDM, run side by side ----
        do_reset();
        mode0   = 2'd1;
        sample0 = {32'd1024, 32'd4000};
        wrreq0  = 1'b1;
        sample4 = 64'h1111_2222_3333_4444;
        wrreq4  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_edge(dvec[i].edge_no);
            wrreq0 = 1'b0;
            wrreq4 = 1'b0;
            check("bck_after_release", bck0, dvec[i].bck);
            check("sck_after_release", sck0, dvec[i].sck);
        end
        check("usedw_one_write", wrusedw0, 3'd1);
        wait_edge(500);
        check("lj_no_underrun_frame1", underrun0, 1'b0);
        wait_slot(1'b0, 128);
        check("lj_ch0_word", word(0, 64, 32), 32'd1024);
        check("lj_ch1_word", word(0, 96, 32), 32'd4000);
        check("lj_lrck_ch0_ones", ones(1, 64, 95), 0);
        check("lj_lrck_ch1_ones", ones(1, 96, 127), 32);
        wait_slot(1'b1, 192);
        check("tdm_slot0_word", word(2, 64, 16), 32'h1111);
        check("tdm_slot1_word", word(2, 80, 16), 32'h2222);
        check("tdm_slot2_word", word(2, 96, 16), 32'h3333);
        check("tdm_slot3_word", word(2, 112, 16), 32'h4444);
        check("tdm_lrck_pulse_count", ones(3, 0, 191), 3);
        check("tdm_lrck_pulse_pos", {lr4[62], lr4[63], lr4[64]}, 3'b010);
        check("tdm_underrun_frame2", underrun4, 1'b1);

        // ---- I2S stereo, with a mid-frame mode change that must be ignored ----
        do_reset();
        mode0   = 2'd0;
        sample0 = {32'd3743, 32'd255};
        wrreq0  = 1'b1;
        wait_edge(1);
        sample0 = {32'd255, 32'd3743};
        wait_edge(2);
        wrreq0 = 1'b0;
        wait_edge(3);
        check("i2s_usedw_two", wrusedw0, 3'd2);
        wait_edge(336);
        mode0 = 2'd1;
        wait_edge(456);
        mode0 = 2'd0;
        wait_edge(700);
        check("i2s_no_underrun", underrun0, 1'b0);
        wait_slot(1'b0, 256);
        check("i2s_lrck_edge", {lr0[95], lr0[96]}, 2'b01);
        check("i2s_ch0_lsb_at_edge", d0[96], 1'b1);
        check("i2s_f1_ch0", word(0, 65, 32), 32'd3743);
        check("i2s_f1_ch1", word(0, 97, 32), 32'd255);
        check("i2s_f2_ch0", word(0, 129, 32), 32'd255);
        check("i2s_f2_ch1", word(0, 161, 32), 32'd3743);
        check("i2s_f3_zeros", ones(0, 193, 255), 0);
        check("i2s_underrun_f3", underrun0, 1'b1);

        // ---- FIFO fill and overflow, table driven ----
        do_reset();
        mode0 = 2'd1;
        for (int i = 0; i < 5; i++) begin
            wrreq0  = 1'b1;
            sample0 = fvec[i].smp;
            @(negedge clk);
            check("fifo_usedw", wrusedw0, fvec[i].used);
            check("fifo_full", wrfull0, fvec[i].full);
            check("fifo_overflow", overflow0, fvec[i].ovf);
        end
        wrreq0 = 1'b0;
        wait_slot(1'b0, 384);
        for (int i = 0; i < 4; i++) begin
            check("fifo_frame_ch0", word(0, 64 * (i + 1), 32), fvec[i].smp[63:32]);
            check("fifo_frame_ch1", word(0, 64 * (i + 1) + 32, 32), fvec[i].smp[31:0]);
        end
        check("fifo_dropped_not_sent", ones(0, 320, 383), 0);
        check("fifo_overflow_sticky", overflow0, 1'b1);
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        check("overflow_cleared", overflow0, 1'b0);

        // ---- Asynchronous reset in the middle of frame bit 10 ----
        do_reset();
        mode0   = 2'd1;
        sample0 = {32'hFFFF_FFFF, 32'h0};
        wrreq0  = 1'b1;
        wait_edge(1);
        sample0 = {32'h1234_5678, 32'h9ABC_DEF0};
        wait_edge(2);
        wrreq0 = 1'b0;
        wait_edge(299);
        check("pre_reset_dout_bck", {dout0, bck0}, 2'b11);
        check("pre_reset_usedw", wrusedw0, 3'd1);
        aclr_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {wrfull0, wrusedw0, underrun0, overflow0, sck0, bck0, lrck0, dout0}, '0);
        @(negedge clk);
        @(negedge clk);
        aclr_n = 1'b1;
        wait_edge(3);
        check("rerelease_bck_high", bck0, 1'b1);
        wait_edge(4);
        check("rerelease_first_fall", bck0, 1'b0);
        wait_slot(1'b0, 128);
        check("stale_frame_not_resumed", ones(0, 0, 127), 0);
        check("rerelease_underrun", underrun0, 1'b1);

        // ---- Clear versus set, and write coinciding with a pop ----
        do_reset();
        mode0 = 2'd1;
        wait_edge(255);
        check("underrun_before_start", underrun0, 1'b0);
        clr0 = 1'b1;
        wait_edge(256);
        check("underrun_set_beats_clear", underrun0, 1'b1);
        wait_edge(257);
        clr0 = 1'b0;
        check("underrun_cleared", underrun0, 1'b0);
        wait_edge(300);
        sample0 = {32'hCAFE_0001, 32'h0BAD_0001};
        wrreq0  = 1'b1;
        wait_edge(301);
        sample0 = {32'hCAFE_0002, 32'h0BAD_0002};
        wait_edge(302);
        wrreq0 = 1'b0;
        wait_edge(511);
        check("usedw_before_pop", wrusedw0, 3'd2);
        sample0 = {32'hCAFE_0003, 32'h0BAD_0003};
        wrreq0  = 1'b1;
        wait_edge(512);
        wrreq0 = 1'b0;
        check("usedw_write_with_pop", wrusedw0, 3'd2);
        check("no_underrun_with_data", underrun0, 1'b0);
        wait_slot(1'b0, 192);
        check("frame_after_pop_ch0", word(0, 128, 32), 32'hCAFE_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_tdm_out.md
Name: i2s_tdm_out

Overview:
Parametrised serial audio transmitter, successor to the fixed 2x32-bit stereo output. It buffers whole multi-channel frames in an internal FIFO and derives sck/bck from clk with integer dividers, so no PLL is needed. It serialises frames MSB-first in I2S, left-justified or TDM format, and reports underrun and overflow. It sits between the synth mixer (frame producer) and the external DAC pins.

Parameters:
SAMPLE_W, 32, bits per channel slot (8..32)
CHANNELS, 2, channels per frame (1..8); TDM mode is forced when CHANNELS>2
FIFO_DEPTH, 4, frames buffered; power of two, >=2
BCK_DIV, 4, clk cycles per bck period; even, >=2
SCK_DIV, 2, clk cycles per sck period; even, >=2

Ports:
clk  in  1  system clock; all logic is on the rising edge
aclr_n  in  1  asynchronous active-low reset
sample  in  CHANNELS*SAMPLE_W  frame; ch0 = top slice [CHANNELS*SAMPLE_W-1 -: SAMPLE_W], ch(N-1) = bottom slice
wrreq  in  1  write strobe; a frame is accepted when wrreq && !wrfull
wrfull  out  1  FIFO holds FIFO_DEPTH frames
wrusedw  out  $clog2(FIFO_DEPTH)+1  frames currently stored
mode  in  2  0=I2S, 1=left-justified, 2=TDM pulse; 3 is treated as 1
clr_status  in  1  clears the sticky flags
underrun  out  1  sticky: a frame start found the FIFO empty
overflow  out  1  sticky: wrreq asserted while wrfull
sck  out  1  master clock, clk/SCK_DIV, 50% duty
bck  out  1  bit clock, clk/BCK_DIV, 50% duty
lrck  out  1  word select / frame sync
dout  out  1  serial data

Behaviour:
- Reset (aclr_n=0, asynchronous): sck=bck=lrck=dout=0, wrfull=0, wrusedw=0, underrun=overflow=0. FIFO, divider counters and bit counter clear. Shift register is all zeros.
- Dividers: dcnt runs 0..BCK_DIV-1. bck goes high when dcnt=BCK_DIV/2-1 and low when dcnt=BCK_DIV-1. The "fall event" is the cycle bck goes low. sck is derived the same way from its own counter. The first fall event occurs BCK_DIV cycles after reset release.
- Frame = FRAME = CHANNELS*SAMPLE_W bck periods. bcnt 0..FRAME-1 advances on each fall event and wraps to 0 (frame start).
- Frame start:
  - FIFO non-empty: pop one frame into the shift register.
  - FIFO empty: load zeros and set underrun.
  - mode is sampled here and held for the whole frame.
  - A write and a pop in the same cycle leave wrusedw unchanged.
- lrck, dout and the shift register change only on fall events; the DAC samples on bck rising edges.
- Left-justified (mode 1): slot k carries MSB-first bit (SAMPLE_W-1-(k mod SAMPLE_W)) of channel k/SAMPLE_W. lrck=0 for ch0, 1 for ch1. When CHANNELS=1, lrck=0 always.
- I2S (mode 0): lrck is as in left-justified, but dout lags by one bck. Slot 0 of a frame carries the LSB of the last channel of the previous frame, which is 0 after reset or underrun.
- TDM (mode 2, or CHANNELS>2 in any mode): lrck=1 for slot FRAME-1 only, one bck before ch0 MSB. Data is left-justified and channels are contiguous.
- FIFO write: wrusedw and wrfull update one cycle after the accepting edge. A write while full is dropped, sets overflow, and leaves contents intact.
- Sticky flags: clr_status clears them on the next edge. A set event in the same cycle as clr_status wins (the flag stays 1).
- A mode change mid-frame has no effect until the next frame start.

Decomposition:
- Shared package audio_pkg: mode encodings (MODE_I2S=0, MODE_LJ=1, MODE_TDM=2) and a clog2 helper constant function.
- One sub-module, audio_frame_fifo: show-ahead FIFO of CHANNELS*SAMPLE_W x FIFO_DEPTH with wrreq/rdreq/full/empty/usedw and async active-low clear.
- Top level holds the dividers, bit counter, shift register and format logic.

Test Plan:
- Defaults, mode 1, write {1024, 4000}: one frame later, bck-sampled ch0 reads 32'd1024 with lrck=0 and ch1 reads 32'd4000 with lrck=1. No underrun after the first full frame.
- Mode 0, write {3743, 255} then {255, 3743}: the MSB of each word appears one bck after the lrck edge. Recovered words are 3743, 255, 255, 3743. The next frame is zeros and underrun=1.
- CHANNELS=4, SAMPLE_W=16, write {16'h1111, 16'h2222, 16'h3333, 16'h4444}: lrck pulses high for exactly 1 bck every 64 bck. Slots decode in order 1111, 2222, 3333, 4444.
- FIFO_DEPTH=4: five writes back-to-back with no frame start: wrusedw=4 and wrfull=1 after the fourth, overflow=1 after the fifth. Only the first four frames are ever transmitted.
- Pull aclr_n low in the middle of frame bit 10: all outputs are 0 immediately. After release, the first fall event comes BCK_DIV clk later, and the stale frame is not resumed.
- Write on the exact cycle of a pop with wrusedw=2: wrusedw stays 2. clr_status coinciding with an underrun event leaves underrun=1.
